// File: rtl/data_cache_responder_if.sv
// Bus bundle for the data-cache responder: load lookup, committed-store and backing-memory handshakes.
// The slave modport is the cache's view; master is the view of the memory stage and backing memory.
interface data_cache_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              data_ready;
  logic [DATA_W-1:0] data_response;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, st_valid, st_addr, st_data, mem_ack, mem_rdata,
    output data_ready, data_response, st_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_addr, st_valid, st_addr, st_data, mem_ack, mem_rdata,
    input  data_ready, data_response, st_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate word cache answering memory-stage load lookups.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module data_cache_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  data_cache_responder_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    WRITE,
    RESPOND
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] resp_word;
  logic              line_updated;
  logic [LINES-1:0]  line_valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              data_ready_c;
  logic              st_ready_c;
  logic              mem_req_c;
  logic              mem_we_c;

  // Both loads and stores look up the line through the latched address.
  assign idx = lat_addr[IDX_W+1:2];
  assign tag = lat_addr[ADDR_W-1:IDX_W+2];
  assign hit = line_valid[idx] && (tag_mem[idx] == tag);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    data_ready_c = 1'b0;
    st_ready_c   = 1'b0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.st_valid && reset) begin
          st_ready_c = 1'b1;
          next_state = WRITE;
        end else if (bus.req_valid) begin
          next_state = LOOKUP;
        end
      end
      LOOKUP:  next_state = hit ? RESPOND : FILL;
      FILL: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) next_state = RESPOND;
      end
      WRITE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        if (bus.mem_ack) next_state = IDLE;
      end
      RESPOND: begin
        data_ready_c = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latching, valid bits and the response word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_addr     <= '0;
      lat_data     <= '0;
      resp_word    <= '0;
      line_updated <= 1'b0;
      line_valid   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.st_valid) begin
            lat_addr     <= bus.st_addr;
            lat_data     <= bus.st_data;
            line_updated <= 1'b0;
          end else if (bus.req_valid) begin
            lat_addr <= bus.req_addr;
          end
        end
        LOOKUP: if (hit) resp_word <= data_mem[idx];
        FILL: begin
          if (bus.mem_ack) begin
            line_valid[idx] <= 1'b1;
            resp_word       <= bus.mem_rdata;
          end
        end
        WRITE:   line_updated <= 1'b1;
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; an abandoned fill never reaches it because reset gates the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == FILL && bus.mem_ack) begin
        tag_mem[idx]  <= tag;
        data_mem[idx] <= bus.mem_rdata;
      end else if (state == WRITE && hit && !line_updated) begin
        data_mem[idx] <= lat_data;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

  assign bus.data_ready    = data_ready_c;
  assign bus.data_response = resp_word;
  assign bus.st_ready      = st_ready_c;
  assign bus.mem_req       = mem_req_c;
  assign bus.mem_we        = mem_we_c;
  assign bus.mem_addr      = mem_req_c ? lat_addr : '0;
  assign bus.mem_wdata     = mem_we_c ? lat_data : '0;

endmodule

// File: tb/tb_data_cache_responder.sv
// Scoreboard bench for data_cache_responder: a word-level model of cache presence and memory contents
// predicts every load result and backing-memory transaction; monitors compare as the DUT presents them.
module tb_data_cache_responder;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINES  = 64;
  localparam int BUDGET = 200;

  typedef struct {
    logic [31:0] data;
    bit          chk_lat;
    int          issue_cyc;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  data_cache_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory contents by word address and which word each line holds.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] dev_mem [int unsigned];
  bit          ref_valid [LINES];
  int unsigned ref_word  [LINES];
  int          ref_hits = 0;
  int          ref_misses = 0;

  exp_t sb_q [$];
  mem_t mem_q [$];

  int mem_latency = 0;
  int late_ack_req = 0;
  int late_ack_done = 0;
  int writes_done = 0;
  bit prev_ready = 1'b0;

  function automatic logic [31:0] default_word(input int unsigned w);
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    return ref_mem.exists(w) ? ref_mem[w] : default_word(w);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Backing memory: checks each request against the expected queue, then acks after a latency.
  initial begin : backing_memory
    mem_t        m;
    int          lat;
    bit          abandoned;
    int unsigned w;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (late_ack_req != late_ack_done) begin
        @(posedge clk); #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        late_ack_done++;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
      end else if (reset && bus.mem_req) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_mem_req: got we=%0d addr %h, none required", bus.mem_we, bus.mem_addr);
          m.we = bus.mem_we; m.addr = bus.mem_addr; m.wdata = bus.mem_wdata;
        end else begin
          m = mem_q.pop_front();
          checkOutput("mem_we", 32'(bus.mem_we), 32'(m.we));
          checkOutput("mem_addr", bus.mem_addr, m.addr);
          checkOutput("mem_wdata", bus.mem_wdata, m.wdata);
        end
        lat = (mem_latency > 0) ? mem_latency : int'($urandom_range(1, 5));
        abandoned = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk);
          if (!reset) begin
            abandoned = 1'b1;
            break;
          end
        end
        if (!abandoned) begin
          #1;
          w = m.addr >> 2;
          bus.mem_ack = 1'b1;
          if (m.we) begin
            dev_mem[w]    = m.wdata;
            bus.mem_rdata = $urandom;
            writes_done++;
          end else begin
            bus.mem_rdata = dev_mem.exists(w) ? dev_mem[w] : default_word(w);
          end
          @(posedge clk); #1;
          bus.mem_ack = 1'b0;
        end
      end
    end
  end

  // Load-response monitor: pops the scoreboard whenever data_ready is presented.
  initial begin : response_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.data_ready) begin
        checkOutput("ready_pulse_width", 32'(prev_ready), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_data_ready: got data %h, no load outstanding", bus.data_response);
        end else begin
          e = sb_q.pop_front();
          checkOutput("load_data", bus.data_response, e.data);
          if (e.chk_lat) checkOutput("hit_latency", 32'(cyc - e.issue_cyc), 32'd2);
        end
      end
      prev_ready = bus.data_ready;
    end
  end

  // Called one time unit after a rising edge with the DUT idle; returns in the same phase.
  task automatic applyStimulus(input bit do_store, input bit do_load, input logic [31:0] st_a,
                               input logic [31:0] st_d, input logic [31:0] ld_a);
    int          w0;
    int          n;
    exp_t        e;
    mem_t        m;
    int unsigned lw;
    int unsigned li;
    w0 = writes_done;
    if (do_store) begin
      m.we = 1'b1; m.addr = st_a; m.wdata = st_d;
      mem_q.push_back(m);
      ref_mem[st_a >> 2] = st_d;
    end
    if (do_load) begin
      lw = ld_a >> 2;
      li = lw % LINES;
      if (ref_valid[li] && ref_word[li] == lw) begin
        ref_hits++;
        e.chk_lat = !do_store;
      end else begin
        ref_misses++;
        ref_valid[li] = 1'b1;
        ref_word[li]  = lw;
        m.we = 1'b0; m.addr = ld_a; m.wdata = '0;
        mem_q.push_back(m);
        e.chk_lat = 1'b0;
      end
      e.data      = ref_read(ld_a);
      e.issue_cyc = cyc;
      sb_q.push_back(e);
    end
    bus.st_valid  = do_store;
    bus.st_addr   = st_a;
    bus.st_data   = st_d;
    bus.req_valid = do_load;
    bus.req_addr  = ld_a;
    if (do_store) begin
      n = 0;
      @(negedge clk);
      while (!bus.st_ready && n < BUDGET) begin @(negedge clk); n++; end
      checkOutput("st_ready_seen", 32'(bus.st_ready), 32'd1);
      @(posedge clk); #1;
      bus.st_valid = 1'b0;
      n = 0;
      while (writes_done == w0 && n < BUDGET) begin @(negedge clk); n++; end
      checkOutput("store_write_through", 32'(writes_done != w0), 32'd1);
      @(posedge clk); #1;
    end
    if (do_load) begin
      n = 0;
      @(negedge clk);
      while (!bus.data_ready && n < BUDGET) begin @(negedge clk); n++; end
      checkOutput("load_response_seen", 32'(bus.data_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_data_ready"}, 32'(bus.data_ready), 32'd0);
    checkOutput({tag, "_st_ready"}, 32'(bus.st_ready), 32'd0);
    checkOutput({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    checkOutput({tag, "_data_response"}, bus.data_response, 32'd0);
`ifdef DCACHE_STATS_EN
    checkOutput({tag, "_hit_count"}, hit_count, 32'd0);
    checkOutput({tag, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  // Reset lands while a fill to 0x300 is waiting on backing memory; a stray ack follows.
  task automatic resetDuringFill();
    mem_t m;
    int   n;
    m.we = 1'b0; m.addr = 32'h300; m.wdata = '0;
    mem_q.push_back(m);
    mem_latency   = 8;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h300;
    n = 0;
    @(negedge clk);
    while (!bus.mem_req && n < BUDGET) begin @(negedge clk); n++; end
    checkOutput("fill_started", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkIdleOutputs("mid_fill_reset");
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
    @(posedge clk); #1;
    reset       = 1'b1;
    mem_latency = 0;
    late_ack_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
      checkOutput("late_ack_data_ready", 32'(bus.data_ready), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    logic [31:0] sa;
    logic [31:0] la;
    int          kind;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    dev_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    mem_latency = 4;
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h100);
    mem_latency = 0;
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h100);
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h200);
`ifdef DCACHE_STATS_EN
    checkOutput("stats_hit_after_mhm", hit_count, 32'd1);
    checkOutput("stats_miss_after_mhm", miss_count, 32'd2);
`endif
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h1234_5678, '0);
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h200, 32'hCAFE_F00D, '0);
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h200);
    applyStimulus(1'b1, 1'b1, 32'h104, 32'h0BAD_C0DE, 32'h104);

    resetDuringFill();
    applyStimulus(1'b0, 1'b1, '0, '0, 32'h100);

    // Small address pool: 8 indexes x 4 tags (plus a high tag bit) forces hits, misses and evictions.
    for (int t = 0; t < 150; t++) begin
      sa   = ((($urandom_range(0, 3) * LINES) + $urandom_range(0, 7)) * 4) | ($urandom_range(0, 1) << 28);
      la   = ((($urandom_range(0, 3) * LINES) + $urandom_range(0, 7)) * 4) | ($urandom_range(0, 1) << 28);
      kind = int'($urandom_range(0, 9));
      if (kind <= 5)      applyStimulus(1'b0, 1'b1, '0, '0, la);
      else if (kind <= 8) applyStimulus(1'b1, 1'b0, sa, $urandom, '0);
      else                applyStimulus(1'b1, 1'b1, sa, $urandom, la);
    end

    repeat (3) @(posedge clk);
    #1;
`ifdef DCACHE_STATS_EN
    checkOutput("stats_hit_final", hit_count, 32'(ref_hits));
    checkOutput("stats_miss_final", miss_count, 32'(ref_misses));
`endif
    checkOutput("load_scoreboard_drained", 32'(sb_q.size()), 32'd0);
    checkOutput("mem_scoreboard_drained", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
